// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5..9 data bits, none/odd/even parity, 1 or 2 stop bits).
// Build option RX_MAJORITY_EN: every bit decision becomes a 3-sample majority vote.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 40,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_Rx,
    output logic                 Rx_done_tick,
    output logic [DATA_BITS-1:0] dout,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_MID   = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic rx_m;
    logic rx_s;
    logic sample;

    // NOTE: non-blocking assignments make rx_s take the previous rx_m, giving two real flop stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= i_Rx;
            rx_s <= rx_m;
        end
    end

`ifdef RX_MAJORITY_EN
    logic rx_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_p <= 1'b1;
        end else begin
            rx_p <= rx_s;
        end
    end

    // rx_m is the value rx_s takes next cycle, so the vote spans T-1..T+1 without extra latency.
    assign sample = (rx_p & rx_s) | (rx_p & rx_m) | (rx_s & rx_m);
`else
    assign sample = rx_s;
`endif

    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 frm_bad;
    logic                 armed;
    logic                 par_bad;
    logic                 stop_bad;

    assign par_bad  = (PARITY_MODE == 1) ? ~(^{shreg, par_bit}) :
                      (PARITY_MODE == 2) ?  (^{shreg, par_bit}) : 1'b0;
    assign stop_bad = frm_bad | ~sample;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            idx          <= '0;
            stop_idx     <= 1'b0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            frm_bad      <= 1'b0;
            armed        <= 1'b0;
            dout         <= '0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            Rx_done_tick <= 1'b0;
        end else begin
            Rx_done_tick <= 1'b0;
            if (rx_s) begin
                armed <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    cnt      <= '0;
                    idx      <= '0;
                    stop_idx <= 1'b0;
                    frm_bad  <= 1'b0;
                    if (!rx_s && armed) begin
                        state <= S_START;
                    end
                end

                S_START: begin
                    if (cnt == CNT_MID) begin
                        cnt   <= '0;
                        state <= sample ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {sample, shreg[DATA_BITS-1:1]};
                        idx   <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            state <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        par_bit <= sample;
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        frm_bad <= stop_bad;
                        // A low stop bit still completes the frame; it is only flagged.
                        if (stop_idx == STOP_LAST) begin
                            state        <= S_IDLE;
                            Rx_done_tick <= 1'b1;
                            dout         <= shreg;
                            parity_err   <= par_bad;
                            frame_err    <= stop_bad;
                            if (stop_bad) begin
                                armed <= 1'b0;
                            end
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four receivers (8N1, 7E1, 8N2, 8O1) fed by independent serial lines.
module tb_uart_rx_cfg;

    localparam int C = 16;
    localparam int H = (C - 1) / 2;

    typedef struct {
        int         k;
        int         cyc;
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } ev_t;

    typedef struct {
        int         lat;
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_line [4];
    logic       done_w  [4];
    logic       pe_w    [4];
    logic       fe_w    [4];
    logic       busy_w  [4];
    logic [7:0] dout0;
    logic [6:0] dout1;
    logic [7:0] dout2;
    logic [7:0] dout3;

    int  cyc         = 0;
    int  vectors     = 0;
    int  miscompares = 0;
    ev_t evq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .i_Rx(rx_line[0]), .Rx_done_tick(done_w[0]),
        .dout(dout0), .parity_err(pe_w[0]), .frame_err(fe_w[0]), .busy(busy_w[0]));
    uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) u_7e1 (
        .clk(clk), .rst_n(rst_n), .i_Rx(rx_line[1]), .Rx_done_tick(done_w[1]),
        .dout(dout1), .parity_err(pe_w[1]), .frame_err(fe_w[1]), .busy(busy_w[1]));
    uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst_n(rst_n), .i_Rx(rx_line[2]), .Rx_done_tick(done_w[2]),
        .dout(dout2), .parity_err(pe_w[2]), .frame_err(fe_w[2]), .busy(busy_w[2]));
    uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst_n(rst_n), .i_Rx(rx_line[3]), .Rx_done_tick(done_w[3]),
        .dout(dout3), .parity_err(pe_w[3]), .frame_err(fe_w[3]), .busy(busy_w[3]));

    function automatic int nb(input int k);
        return (k == 1) ? 7 : 8;
    endfunction

    function automatic int pm(input int k);
        return (k == 1) ? 2 : (k == 3) ? 1 : 0;
    endfunction

    function automatic int ns(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    function automatic logic [8:0] dout_of(input int k);
        case (k)
            0:       return {1'b0, dout0};
            1:       return {2'b0, dout1};
            2:       return {1'b0, dout2};
            default: return {1'b0, dout3};
        endcase
    endfunction

    // Reference: frame outcome from the line-level rules (parity by counting ones).
    function automatic exp_t model(input int k, input logic [8:0] d, input logic pbit,
                                   input logic [1:0] stops);
        exp_t e;
        int   ones;
        e.d  = d & 9'((1 << nb(k)) - 1);
        ones = $countones(e.d) + int'(pbit);
        case (pm(k))
            1:       e.pe = (ones % 2 == 0);
            2:       e.pe = (ones % 2 == 1);
            default: e.pe = 1'b0;
        endcase
        e.fe  = !stops[0] || (ns(k) == 2 && !stops[1]);
        // Fall is launched half a cycle before the first edge that sees it.
        e.lat = 1 + 2 + H + (nb(k) + ((pm(k) != 0) ? 1 : 0) + ns(k)) * C + 1;
        return e;
    endfunction

    always @(negedge clk) begin
        ev_t m;
        for (int k = 0; k < 4; k++) begin
            if (done_w[k] === 1'b1) begin
                m.k   = k;
                m.cyc = cyc;
                m.d   = dout_of(k);
                m.pe  = pe_w[k];
                m.fe  = fe_w[k];
                evq.push_back(m);
            end
        end
    end

    task automatic drive_bit(input int k, input logic v, input bit glitch);
        rx_line[k] = v;
        if (glitch) begin
            repeat (H + 1) @(negedge clk);
            rx_line[k] = ~v;
            @(negedge clk);
            rx_line[k] = v;
            repeat (C - H - 2) @(negedge clk);
        end else begin
            repeat (C) @(negedge clk);
        end
    endtask

    task automatic send_frame(input int k, input logic [8:0] d, input logic pbit,
                              input logic [1:0] stops, input bit glitch, output int t_fall);
        t_fall = cyc;
        drive_bit(k, 1'b0, 1'b0);
        for (int i = 0; i < nb(k); i++) drive_bit(k, d[i], glitch);
        if (pm(k) != 0) drive_bit(k, pbit, 1'b0);
        for (int i = 0; i < ns(k); i++) drive_bit(k, stops[i], 1'b0);
    endtask

    task automatic idle_line(input int k, input int bits);
        rx_line[k] = 1'b1;
        repeat (bits * C) @(negedge clk);
    endtask

    // Pulls every recorded strobe of receiver k; returns how many and the first one.
    task automatic take_event(input int k, output int n, output ev_t ev);
        ev_t keep [$];
        n      = 0;
        ev.k   = k;
        ev.cyc = -1;
        ev.d   = 9'h1ff;
        ev.pe  = 1'bx;
        ev.fe  = 1'bx;
        foreach (evq[i]) begin
            if (evq[i].k == k) begin
                if (n == 0) ev = evq[i];
                n++;
            end else begin
                keep.push_back(evq[i]);
            end
        end
        evq = keep;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            vectors++; if (done_w[k] !== 1'b0) begin miscompares++; $display("FAIL reset_tick[%0d]: got %b want 0", k, done_w[k]); end
            vectors++; if (busy_w[k] !== 1'b0) begin miscompares++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy_w[k]); end
            vectors++; if (pe_w[k] !== 1'b0) begin miscompares++; $display("FAIL reset_pe[%0d]: got %b want 0", k, pe_w[k]); end
            vectors++; if (fe_w[k] !== 1'b0) begin miscompares++; $display("FAIL reset_fe[%0d]: got %b want 0", k, fe_w[k]); end
            vectors++; if (dout_of(k) !== 9'h000) begin miscompares++; $display("FAIL reset_dout[%0d]: got %h want 000", k, dout_of(k)); end
        end
    endtask

    task automatic test_8n1();
        int t, n; ev_t ev; exp_t e;
        send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b0, t);
        e = model(0, 9'h0A5, 1'b0, 2'b11);
        idle_line(0, 2);
        take_event(0, n, ev);
        vectors++; if (n !== 1) begin miscompares++; $display("FAIL a5_count: got %0d want 1", n); end
        vectors++; if (ev.cyc !== t + e.lat) begin miscompares++; $display("FAIL a5_latency: got %0d want %0d", ev.cyc - t, e.lat); end
        vectors++; if (ev.d !== e.d) begin miscompares++; $display("FAIL a5_dout: got %h want %h", ev.d, e.d); end
        vectors++; if (ev.pe !== e.pe) begin miscompares++; $display("FAIL a5_pe: got %b want %b", ev.pe, e.pe); end
        vectors++; if (ev.fe !== e.fe) begin miscompares++; $display("FAIL a5_fe: got %b want %b", ev.fe, e.fe); end
    endtask

    task automatic test_glitch_reject();
        int n; ev_t ev; bit saw_busy = 1'b0;
        rx_line[0] = 1'b0;
        repeat (3) @(negedge clk);
        rx_line[0] = 1'b1;
        for (int i = 0; i < 2 * C; i++) begin
            @(negedge clk);
            if (busy_w[0] === 1'b1) saw_busy = 1'b1;
        end
        take_event(0, n, ev);
        vectors++; if (saw_busy !== 1'b1) begin miscompares++; $display("FAIL glitch_start_seen: got %b want 1", saw_busy); end
        vectors++; if (busy_w[0] !== 1'b0) begin miscompares++; $display("FAIL glitch_back_idle: got %b want 0", busy_w[0]); end
        vectors++; if (n !== 0) begin miscompares++; $display("FAIL glitch_strobes: got %0d want 0", n); end
        vectors++; if (dout0 !== 8'hA5) begin miscompares++; $display("FAIL glitch_dout: got %h want a5", dout0); end
    endtask

    task automatic test_parity();
        int t, n; ev_t ev; exp_t e;
        for (int p = 1; p >= 0; p--) begin
            send_frame(1, 9'h035, 1'(p), 2'b11, 1'b0, t);
            e = model(1, 9'h035, 1'(p), 2'b11);
            idle_line(1, 2);
            take_event(1, n, ev);
            vectors++; if (n !== 1) begin miscompares++; $display("FAIL par%0d_count: got %0d want 1", p, n); end
            vectors++; if (ev.cyc !== t + e.lat) begin miscompares++; $display("FAIL par%0d_latency: got %0d want %0d", p, ev.cyc - t, e.lat); end
            vectors++; if (ev.d !== e.d) begin miscompares++; $display("FAIL par%0d_dout: got %h want %h", p, ev.d, e.d); end
            vectors++; if (ev.pe !== e.pe) begin miscompares++; $display("FAIL par%0d_pe: got %b want %b", p, ev.pe, e.pe); end
            vectors++; if (ev.fe !== e.fe) begin miscompares++; $display("FAIL par%0d_fe: got %b want %b", p, ev.fe, e.fe); end
        end
    endtask

    task automatic test_two_stop_break();
        int t, n; ev_t ev; exp_t e;
        send_frame(2, 9'h03C, 1'b0, 2'b01, 1'b0, t);
        e = model(2, 9'h03C, 1'b0, 2'b01);
        repeat (100 * C) @(negedge clk);
        take_event(2, n, ev);
        vectors++; if (n !== 1) begin miscompares++; $display("FAIL break_count: got %0d want 1", n); end
        vectors++; if (ev.d !== e.d) begin miscompares++; $display("FAIL break_dout: got %h want %h", ev.d, e.d); end
        vectors++; if (ev.fe !== e.fe) begin miscompares++; $display("FAIL break_fe: got %b want %b", ev.fe, e.fe); end
        vectors++; if (busy_w[2] !== 1'b0) begin miscompares++; $display("FAIL break_busy: got %b want 0", busy_w[2]); end
        idle_line(2, 2);
        send_frame(2, 9'h096, 1'b0, 2'b11, 1'b0, t);
        e = model(2, 9'h096, 1'b0, 2'b11);
        idle_line(2, 2);
        take_event(2, n, ev);
        vectors++; if (n !== 1) begin miscompares++; $display("FAIL recover_count: got %0d want 1", n); end
        vectors++; if (ev.d !== e.d) begin miscompares++; $display("FAIL recover_dout: got %h want %h", ev.d, e.d); end
        vectors++; if (ev.fe !== e.fe) begin miscompares++; $display("FAIL recover_fe: got %b want %b", ev.fe, e.fe); end
    endtask

    task automatic test_reset_mid_frame();
        int t, n; ev_t ev; exp_t e;
        logic [8:0] d = 9'h05A;
        drive_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, d[i], 1'b0);
        rx_line[0] = d[4];
        repeat (H) @(negedge clk);
        rst_n = 1'b0;
        rx_line[0] = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (busy_w[0] !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy_w[0]); end
        vectors++; if (dout0 !== 8'h00) begin miscompares++; $display("FAIL midrst_dout: got %h want 00", dout0); end
        vectors++; if (fe_w[0] !== 1'b0) begin miscompares++; $display("FAIL midrst_fe: got %b want 0", fe_w[0]); end
        rst_n = 1'b1;
        repeat (4 * C) @(negedge clk);
        take_event(0, n, ev);
        vectors++; if (n !== 0) begin miscompares++; $display("FAIL midrst_stray: got %0d want 0", n); end
        send_frame(0, 9'h081, 1'b0, 2'b11, 1'b0, t);
        e = model(0, 9'h081, 1'b0, 2'b11);
        idle_line(0, 2);
        take_event(0, n, ev);
        vectors++; if (n !== 1) begin miscompares++; $display("FAIL post_rst_count: got %0d want 1", n); end
        vectors++; if (ev.cyc !== t + e.lat) begin miscompares++; $display("FAIL post_rst_latency: got %0d want %0d", ev.cyc - t, e.lat); end
        vectors++; if (ev.d !== e.d) begin miscompares++; $display("FAIL post_rst_dout: got %h want %h", ev.d, e.d); end
    endtask

    task automatic test_back_to_back();
        int t, n; ev_t ev; exp_t e;
        logic [8:0] d;
        logic       pbit;
        for (int f = 0; f < 3; f++) begin
            d    = 9'($urandom_range(0, 255));
            pbit = 1'($urandom_range(0, 1));
            send_frame(3, d, pbit, 2'b11, 1'b0, t);
            e = model(3, d, pbit, 2'b11);
            take_event(3, n, ev);
            vectors++; if (n !== 1) begin miscompares++; $display("FAIL b2b%0d_count: got %0d want 1", f, n); end
            vectors++; if (ev.cyc !== t + e.lat) begin miscompares++; $display("FAIL b2b%0d_latency: got %0d want %0d", f, ev.cyc - t, e.lat); end
            vectors++; if (ev.d !== e.d) begin miscompares++; $display("FAIL b2b%0d_dout: got %h want %h", f, ev.d, e.d); end
            vectors++; if (ev.pe !== e.pe) begin miscompares++; $display("FAIL b2b%0d_pe: got %b want %b", f, ev.pe, e.pe); end
        end
        idle_line(3, 2);
    endtask

    task automatic test_random();
        int t, n; ev_t ev; exp_t e;
        logic [8:0] d;
        logic       pbit;
        logic [1:0] stops;
        for (int k = 0; k < 4; k++) begin
            for (int f = 0; f < 6; f++) begin
                d        = 9'($urandom_range(0, (1 << nb(k)) - 1));
                pbit     = 1'($urandom_range(0, 1));
                stops[0] = ($urandom_range(0, 3) != 0);
                stops[1] = ($urandom_range(0, 3) != 0);
                send_frame(k, d, pbit, stops, 1'b0, t);
                e = model(k, d, pbit, stops);
                idle_line(k, 2);
                take_event(k, n, ev);
                vectors++; if (n !== 1) begin miscompares++; $display("FAIL rand%0d_%0d_count: got %0d want 1", k, f, n); end
                vectors++; if (ev.cyc !== t + e.lat) begin miscompares++; $display("FAIL rand%0d_%0d_latency: got %0d want %0d", k, f, ev.cyc - t, e.lat); end
                vectors++; if (ev.d !== e.d) begin miscompares++; $display("FAIL rand%0d_%0d_dout: got %h want %h", k, f, ev.d, e.d); end
                vectors++; if (ev.pe !== e.pe) begin miscompares++; $display("FAIL rand%0d_%0d_pe: got %b want %b", k, f, ev.pe, e.pe); end
                vectors++; if (ev.fe !== e.fe) begin miscompares++; $display("FAIL rand%0d_%0d_fe: got %b want %b", k, f, ev.fe, e.fe); end
            end
        end
    endtask

`ifdef RX_MAJORITY_EN
    task automatic test_majority_glitch();
        int t, n; ev_t ev; exp_t e;
        send_frame(0, 9'h0C3, 1'b0, 2'b11, 1'b1, t);
        e = model(0, 9'h0C3, 1'b0, 2'b11);
        idle_line(0, 2);
        take_event(0, n, ev);
        vectors++; if (n !== 1) begin miscompares++; $display("FAIL maj_count: got %0d want 1", n); end
        vectors++; if (ev.cyc !== t + e.lat) begin miscompares++; $display("FAIL maj_latency: got %0d want %0d", ev.cyc - t, e.lat); end
        vectors++; if (ev.d !== e.d) begin miscompares++; $display("FAIL maj_dout: got %h want %h", ev.d, e.d); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) rx_line[k] = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        test_8n1();
        test_glitch_reject();
        test_parity();
        test_two_stop_break();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
`ifdef RX_MAJORITY_EN
        test_majority_glitch();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
